// File: rtl/dice_pkg.sv
// Shared types and constants for the electronic-dice blocks: reader FSM states,
// legal face range and the 7-LED pip patterns.
package dice_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ROLLING,
    SETTLE,
    SHOW
  } state_e;

  localparam logic [2:0] FACE_MIN = 3'd1;
  localparam logic [2:0] FACE_MAX = 3'd6;

  // LED positions on the face
  localparam int PIP_TL = 0;
  localparam int PIP_TR = 1;
  localparam int PIP_ML = 2;
  localparam int PIP_C  = 3;
  localparam int PIP_MR = 4;
  localparam int PIP_BL = 5;
  localparam int PIP_BR = 6;

  localparam logic [6:0] PIPS_1 = 7'h08;
  localparam logic [6:0] PIPS_2 = 7'h41;
  localparam logic [6:0] PIPS_3 = 7'h49;
  localparam logic [6:0] PIPS_4 = 7'h63;
  localparam logic [6:0] PIPS_5 = 7'h6B;
  localparam logic [6:0] PIPS_6 = 7'h77;

endpackage

// File: rtl/dice_reader_if.sv
// Dice-side inputs and LED/score outputs of the dice reader.
// master = dice/board side, slave = reader.
interface dice_reader_if #(
  parameter int SUM_W = 8,
  parameter int CNT_W = 6
);
  logic             button;
  logic [2:0]       throw;
  logic             clr_score;
  logic [6:0]       pips;
  logic [2:0]       result;
  logic             valid;
  logic             err;
  logic [SUM_W-1:0] total;
  logic [CNT_W-1:0] count;

  modport master (
    output button, throw, clr_score,
    input  pips, result, valid, err, total, count
  );

  modport slave (
    input  button, throw, clr_score,
    output pips, result, valid, err, total, count
  );
endinterface

// File: rtl/dice_pip_decoder.sv
// Combinational face -> pip pattern; illegal faces give a blank face.
module dice_pip_decoder
  import dice_pkg::*;
(
  input  logic [2:0] face,
  output logic [6:0] pips
);
  always_comb begin
    pips = 7'h00;
    case (face)
      3'd1: pips = PIPS_1;
      3'd2: pips = PIPS_2;
      3'd3: pips = PIPS_3;
      3'd4: pips = PIPS_4;
      3'd5: pips = PIPS_5;
      3'd6: pips = PIPS_6;
      default: pips = 7'h00;
    endcase
  end
endmodule

// File: rtl/dice_reader.sv
// Dice consumer: waits for the throw to settle after release, latches the face,
// drives the pip LEDs and keeps a saturating total and throw count.
module dice_reader
  import dice_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int SUM_W         = 8,
  parameter int CNT_W         = 6
) (
  input logic clk,
  input logic rst,
  dice_reader_if.slave bus
);
  localparam int SC_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;

  state_e           state_q, state_d;
  logic [SC_W-1:0]  settle_cnt_q, settle_cnt_d;
  logic [2:0]       prev_throw_q, prev_throw_d;
  logic [2:0]       result_q, result_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [SUM_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [6:0]       pips_q, pips_d;
  logic [6:0]       face_pips;
  logic [SUM_W:0]   sum_ext;
  logic             stable, legal;

  dice_pip_decoder u_dec (.face(result_q), .pips(face_pips));

  assign stable  = (bus.throw == prev_throw_q);
  assign legal   = (bus.throw >= FACE_MIN) && (bus.throw <= FACE_MAX);
  assign sum_ext = {1'b0, total_q} + (SUM_W+1)'(bus.throw);

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    prev_throw_d = prev_throw_q;
    result_d     = result_q;
    valid_d      = 1'b0;
    err_d        = err_q;
    total_d      = total_q;
    count_d      = count_q;
    case (state_q)
      IDLE: if (bus.button) state_d = ROLLING;
      ROLLING: begin
        if (!bus.button) begin
          state_d      = SETTLE;
          settle_cnt_d = '0;
          prev_throw_d = bus.throw;
        end
      end
      SETTLE: begin
        prev_throw_d = bus.throw;
        settle_cnt_d = stable ? settle_cnt_q + 1'b1 : '0;
        if (bus.button) begin
          state_d = ROLLING;
        end else if (stable && settle_cnt_q == SC_W'(SETTLE_CYCLES-2)) begin
          if (legal) begin
            state_d  = SHOW;
            result_d = bus.throw;
            valid_d  = 1'b1;
            err_d    = 1'b0;
            total_d  = sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
            count_d  = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + 1'b1;
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
      end
      SHOW: if (bus.button) state_d = ROLLING;
      default: state_d = IDLE;
    endcase
    // Clear beats a same-cycle acceptance for the score only
    if (bus.clr_score) begin
      total_d = '0;
      count_d = '0;
    end
    pips_d = (state_q == SHOW) ? face_pips : 7'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      settle_cnt_q <= '0;
      prev_throw_q <= '0;
      result_q     <= '0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
      total_q      <= '0;
      count_q      <= '0;
      pips_q       <= '0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      prev_throw_q <= prev_throw_d;
      result_q     <= result_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      total_q      <= total_d;
      count_q      <= count_d;
      pips_q       <= pips_d;
    end
  end

  assign bus.pips   = pips_q;
  assign bus.result = result_q;
  assign bus.valid  = valid_q;
  assign bus.err    = err_q;
  assign bus.total  = total_q;
  assign bus.count  = count_q;
endmodule

// File: tb/tb_dice_reader.sv
// Directed bench for dice_reader: a default instance and a narrow-score instance
// (SUM_W=4, CNT_W=2) share the same stimulus.
module tb_dice_reader;
  import dice_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       button;
  logic [2:0] throw;
  logic       clr_score;
  int         checks = 0;
  int         errors = 0;
  logic [2:0] tog_seq [6] = '{3'd2, 3'd3, 3'd2, 3'd2, 3'd2, 3'd2};

  always #5 clk = ~clk;

  dice_reader_if #(.SUM_W(8), .CNT_W(6)) b1 ();
  dice_reader_if #(.SUM_W(4), .CNT_W(2)) b2 ();

  assign b1.button = button;  assign b2.button = button;
  assign b1.throw = throw;    assign b2.throw = throw;
  assign b1.clr_score = clr_score;  assign b2.clr_score = clr_score;

  dice_reader #(.SETTLE_CYCLES(4), .SUM_W(8), .CNT_W(6)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  dice_reader #(.SETTLE_CYCLES(4), .SUM_W(4), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Roll, then release with face f held. Counting the cycle in which the
  // release is first seen as cycle 1, valid must be high only in cycle 5.
  task automatic roll(input string tag, input logic [2:0] f);
    button = 1'b1;
    tick();
    tick();
    button = 1'b0;
    throw  = f;
    for (int n = 1; n <= 4; n++) begin
      tick();
      chk({tag, "_vld1"}, b1.valid, (n == 4));
      chk({tag, "_vld2"}, b2.valid, (n == 4));
    end
    chk({tag, "_res"}, b1.result, f);
    tick();
    chk({tag, "_vld_end"}, b1.valid, 0);
  endtask

  initial begin
    rst = 1'b1; button = 1'b0; throw = 3'd0; clr_score = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_pips", b1.pips, 0);
    chk("rst_result", b1.result, 0);
    chk("rst_valid", b1.valid, 0);
    chk("rst_err", b1.err, 0);
    chk("rst_total", b1.total, 0);
    chk("rst_count", b1.count, 0);

    // Reset in the middle of SETTLE discards the roll
    button = 1'b1; tick(); tick();
    button = 1'b0; throw = 3'd3;
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_rst_valid", b1.valid, 0);
    chk("mid_rst_result", b1.result, 0);
    chk("mid_rst_total", b1.total, 0);
    chk("mid_rst_count", b1.count, 0);
    // A throw held stable afterwards must not be accepted from IDLE
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("mid_rst_idle_vld", b1.valid, 0);
    end
    chk("mid_rst_idle_res", b1.result, 0);

    // Press 5 clocks, release at 4
    button = 1'b1;
    repeat (5) tick();
    button = 1'b0; throw = 3'd4;
    for (int n = 1; n <= 4; n++) begin
      tick();
      chk("lat_valid", b1.valid, (n == 4));
    end
    chk("r4_result", b1.result, 4);
    chk("r4_total", b1.total, 4);
    chk("r4_count", b1.count, 1);
    chk("r4_pips_lag", b1.pips, 0);
    tick();
    chk("r4_pips", b1.pips, 7'h63);
    chk("r4_valid_low", b1.valid, 0);

    clr_score = 1'b1; tick(); clr_score = 1'b0;
    chk("clr_total", b1.total, 0);
    chk("clr_count", b1.count, 0);
    chk("clr_result", b1.result, 4);

    roll("r6", 3'd6);
    chk("r6_pips", b1.pips, 7'h77);
    roll("r5", 3'd5);
    chk("r65_total", b1.total, 11);
    chk("r65_count", b1.count, 2);
    chk("r5_pips", b1.pips, 7'h6B);
    button = 1'b1; tick(); tick();
    chk("repress_pips", b1.pips, 0);

    // Release while throw toggles 2,3,2 then holds at 2
    button = 1'b0;
    for (int i = 0; i < 6; i++) begin
      throw = tog_seq[i];
      tick();
      chk("tog_valid", b1.valid, (i == 5));
    end
    tick();
    chk("tog_result", b1.result, 2);
    chk("tog_pips", b1.pips, 7'h41);
    chk("tog_total", b1.total, 13);

    // One-cycle button glitch in SETTLE restarts the settle window
    button = 1'b1; tick();
    button = 1'b0; throw = 3'd5;
    tick(); tick();
    button = 1'b1; tick();
    chk("glitch_vld", b1.valid, 0);
    button = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("glitch_resettle_vld", b1.valid, (k == 3));
    end
    chk("glitch_count", b1.count, 4);
    tick();

    // Illegal faces 0 and 7
    button = 1'b1; tick();
    button = 1'b0; throw = 3'd0;
    for (int n = 1; n <= 6; n++) begin
      tick();
      chk("ill0_vld", b1.valid, 0);
      chk("ill0_err", b1.err, (n >= 4));
    end
    chk("ill0_pips", b1.pips, 0);
    button = 1'b1; tick();
    button = 1'b0; throw = 3'd7;
    for (int n = 1; n <= 6; n++) begin
      tick();
      chk("ill7_vld", b1.valid, 0);
    end
    chk("ill7_err", b1.err, 1);
    chk("ill_total", b1.total, 18);
    chk("ill_result", b1.result, 5);
    roll("r1", 3'd1);
    chk("r1_err", b1.err, 0);
    chk("r1_pips", b1.pips, 7'h08);
    chk("r1_total", b1.total, 19);

    // Saturation on the narrow instance
    rst = 1'b1; tick(); rst = 1'b0;
    chk("sat_rst_total", b2.total, 0);
    roll("s1", 3'd6);
    chk("s1_total", b2.total, 6);
    roll("s2", 3'd6);
    chk("s2_total", b2.total, 12);
    roll("s3", 3'd6);
    chk("s3_total", b2.total, 15);
    chk("s3_count", b2.count, 3);
    roll("s4", 3'd6);
    chk("s4_total", b2.total, 15);
    chk("s4_count", b2.count, 3);
    chk("s4_total_wide", b1.total, 24);

    // Clear coincident with an acceptance of 3
    button = 1'b1; tick();
    button = 1'b0; throw = 3'd3;
    tick(); tick(); tick();
    clr_score = 1'b1; tick(); clr_score = 1'b0;
    chk("clracc_total2", b2.total, 0);
    chk("clracc_count2", b2.count, 0);
    chk("clracc_result2", b2.result, 3);
    chk("clracc_valid2", b2.valid, 1);
    chk("clracc_total1", b1.total, 0);
    chk("clracc_valid1", b1.valid, 1);
    tick();
    chk("clracc_pips", b2.pips, 7'h49);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
